cmp32_lteq_rr_sched: RTL
========================

// Module: cmp32_lteq_rr_sched
// PURPOSE
// - Shares one combinational 32-bit signed a<=b comparator among N_REQ requesters.
// - Round-robin arbiter: one request per cycle; drives the comparator operands and
//   captures cmp_le.
// - Returns {id, result} on a valid/ready response port.
// - Sits between the crypto control units and the single comparator instance.
// PARAMETERS
// - N_REQ  4   number of requesters (2..8)
// - ID_W   2   requester id width, = clog2(N_REQ)
// - W      32  operand width; the comparator is fixed signed 32-bit
// PORTS
// - clk        in   1        rising-edge clock
// - rst_n      in   1        async active-low reset
// - req_valid  in   N_REQ    per-requester request valid
// - req_ready  out  N_REQ    one-hot accept strobe; at most one bit set
// - req_a      in   N_REQ*W  packed operand a; slice i = [i*W +: W]
// - req_b      in   N_REQ*W  packed operand b
// - cmp_a      out  W        operand a to comparator (x0..x31)
// - cmp_b      out  W        operand b to comparator (x32..x63)
// - cmp_le     in   1        comparator result (y0): $signed(a) <= $signed(b)
// - rsp_valid  out  1        response valid
// - rsp_ready  in   1        response consumer ready
// - rsp_id     out  ID_W     id of the answered requester
// - rsp_le     out  1        registered comparison result
// BEHAVIOUR
// - Reset values (async, on rst_n low):
//   - rsp_valid=0, rsp_id=0, rsp_le=0, RR pointer ptr=N_REQ-1, state=IDLE, stage regs invalid.
//   - Combinational outputs (req_ready, cmp_a, cmp_b) are 0 while rst_n is low.
// - Arbitration:
//   - Search req_valid starting at index (ptr+1) mod N_REQ, wrapping; the first set bit wins.
//   - ptr updates to the winner index only when a request is accepted.
// - Accept condition: can_issue = !out_full | rsp_ready (issue-slot rule; see CONFIGURATION).
//   - req_ready[g] = req_valid[g] & can_issue.
//   - A request transfers on req_valid[i] & req_ready[i].
// - Operand mux: cmp_a/cmp_b = winner's operands in the accept cycle, else held at the last issued operands.
// - Response FSM:
//   - IDLE: rsp_valid=0.
//     - accept -> RESP.
//   - RESP: rsp_valid=1.
//     - rsp_ready & accept -> RESP (new data).
//     - rsp_ready & !accept -> IDLE.
//     - !rsp_ready -> STALL.
//   - STALL: rsp_valid=1; rsp_id and rsp_le are frozen.
//     - rsp_ready -> RESP if a new accept occurs in the same cycle, else IDLE.
// - Latency: accept at edge t -> rsp_valid=1 after edge t+1 (1 cycle). Full throughput 1/cycle.
// - Simultaneous drain and accept: the output register is overwritten in the same cycle; no bubble and no loss.
// - No request is dropped. A requester whose req_valid=1 gets req_ready within N_REQ accepts.
// - req_valid deasserted before accept: the request is withdrawn; no response.
// - rst_n low mid-operation: any in-flight result is discarded; no response after reset.
// - Signedness: the comparator owns the semantics. Examples:
//   - 0x80000000 <= 0x7FFFFFFF gives 1.
//   - 0xFFFFFFFF <= 0x00000000 gives 1.
//   - equal operands give 1.
// CONFIGURATION
// - Macro CMP_SCHED_PIPE_EN.
// - Undefined: cmp_le is captured directly into the output register.
//   - Latency 1; operand path and comparator in one cycle.
// - Defined: adds a stage register (s1_valid, s1_id, s1_le) between cmp_le and the output register.
//   - Latency 2; throughput still 1/cycle.
//   - can_issue = !s1_valid | !out_full | rsp_ready, i.e. stage 1 is free or advances this cycle.
//   - s1 advances to the output when !out_full | rsp_ready.
//   - Reset clears s1_valid.
// TESTING
// - Single request: req0 a=5, b=5 -> req_ready[0]=1 one cycle; rsp_valid after 1 cycle
//   (2 with PIPE_EN); rsp_id=0, rsp_le=1.
// - Signed edge: req2 a=0x80000000, b=0x7FFFFFFF -> rsp_le=1.
//   Then a=0x00000001, b=0xFFFFFFFF -> rsp_le=0.
// - Contention: all 4 valid continuously from reset, rsp_ready=1 -> grants 0,1,2,3,0,...
//   One rsp per cycle with matching ids.
// - Backpressure: rsp_ready=0 for 5 cycles with 2 pending -> rsp_id/rsp_le stable; req_ready=0
//   (no PIPE_EN; with PIPE_EN one extra accept).
//   Release -> both responses delivered in order, none lost.
// - Reset mid-flight: rst_n=0 in the cycle after accept -> rsp_valid=0 immediately; ptr=3;
//   the next grant after reset goes to req0.
// - Withdrawal: req1 valid for one cycle while req0 wins, then drops -> exactly one response (id 0).

Source files
------------

// File: rtl/cmp32_lteq_rr_sched_if.sv
// ----------------------------------------------------------------------------
// cmp32_lteq_rr_sched_if
// Request/response bundle between the crypto control units and the shared
// signed-compare scheduler.
//   req_valid [N_REQ]    per-requester request valid
//   req_ready [N_REQ]    one-hot accept strobe from the scheduler
//   req_a/req_b          packed operands, slice i = [i*W +: W]
//   rsp_valid/rsp_ready  response handshake
//   rsp_id               id of the answered requester
//   rsp_le               comparison result, $signed(a) <= $signed(b)
// Modports: master = requesters plus response consumer, slave = scheduler.
// ----------------------------------------------------------------------------
interface cmp32_lteq_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int W     = 32
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_le;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_le
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_le
  );
endinterface

// File: rtl/cmp32_lteq_rr_sched.sv
// ----------------------------------------------------------------------------
// cmp32_lteq_rr_sched
// Shares one external combinational signed 32-bit a<=b comparator among
// N_REQ requesters. A round-robin arbiter accepts at most one request per
// cycle, steers the winner's operands onto cmp_a/cmp_b, captures cmp_le and
// returns {id, result} on a valid/ready response port.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      cmp32_lteq_rr_sched_if.slave (requests in, responses out)
//   cmp_a    operand a to the comparator
//   cmp_b    operand b to the comparator
//   cmp_le   comparator result
//
// Build option: define CMP_SCHED_PIPE_EN to insert a stage register between
// cmp_le and the output register (latency 2, still one result per cycle).
// Without it the comparator result is captured straight into the output
// register (latency 1).
// ----------------------------------------------------------------------------
module cmp32_lteq_rr_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int W     = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  cmp32_lteq_rr_sched_if.slave        bus,
  output logic [W-1:0]                cmp_a,
  output logic [W-1:0]                cmp_b,
  input  logic                        cmp_le
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t          state_r;
  logic            rsp_valid_r;
  logic [ID_W-1:0] rsp_id_r;
  logic            rsp_le_r;
  logic [ID_W-1:0] ptr_r;
  logic [W-1:0]    hold_a_r;
  logic [W-1:0]    hold_b_r;

  logic [ID_W:0]    pick_s;
  logic [ID_W-1:0]  win_idx_s;
  logic             accept_s;
  logic             can_issue_s;
  logic [N_REQ-1:0] grant_s;
  logic             load_s;
  logic [ID_W-1:0]  load_id_s;
  logic             load_le_s;

  // Round-robin pick: scan from ptr+1 upward with wrap; the nearest set bit
  // wins. The loop runs from farthest to nearest so the nearest overwrites.
  // Returns {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx_w;
    int              idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx   = (int'(ptr) + k) % N_REQ;
      idx_w = idx[ID_W-1:0];
      if (valid[idx_w]) begin
        res = {1'b1, idx_w};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

`ifdef CMP_SCHED_PIPE_EN
  logic            s1_valid_r;
  logic [ID_W-1:0] s1_id_r;
  logic            s1_le_r;
  logic            adv_s;

  // Stage 1 moves into the output register whenever the output is empty or draining.
  assign adv_s       = !rsp_valid_r | bus.rsp_ready;
  assign can_issue_s = !s1_valid_r | adv_s;
  assign load_s      = s1_valid_r & adv_s;
  assign load_id_s   = s1_id_r;
  assign load_le_s   = s1_le_r;

  // Stage register between the comparator and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_id_r    <= '0;
      s1_le_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        s1_valid_r <= 1'b1;
        s1_id_r    <= win_idx_s;
        s1_le_r    <= cmp_le;
      end else if (adv_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
    end
  end
`else
  // Accepting while the output register drains overwrites it in the same cycle.
  assign can_issue_s = !rsp_valid_r | bus.rsp_ready;
  assign load_s      = accept_s;
  assign load_id_s   = win_idx_s;
  assign load_le_s   = cmp_le;
`endif

  // Arbitration and one-hot grant; everything is gated off while in reset.
  always_comb begin
    pick_s    = rr_pick(bus.req_valid, ptr_r);
    win_idx_s = pick_s[ID_W-1:0];
    accept_s  = pick_s[ID_W] & can_issue_s & rst_n;
    grant_s   = '0;
    if (accept_s) begin
      grant_s[win_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Operand mux: winner's operands in the accept cycle, otherwise the last issued pair.
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    if (!rst_n) begin
      cmp_a = '0;
      cmp_b = '0;
    end else if (accept_s) begin
      cmp_a = bus.req_a[int'(win_idx_s)*W +: W];
      cmp_b = bus.req_b[int'(win_idx_s)*W +: W];
    end else begin
      cmp_a = hold_a_r;
      cmp_b = hold_b_r;
    end
  end

  // Round-robin pointer and operand hold registers, updated only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r    <= ID_W'(N_REQ - 1);
      hold_a_r <= '0;
      hold_b_r <= '0;
    end else if (accept_s) begin
      ptr_r    <= win_idx_s;
      hold_a_r <= cmp_a;
      hold_b_r <= cmp_b;
    end else begin
      ptr_r    <= ptr_r;
      hold_a_r <= hold_a_r;
      hold_b_r <= hold_b_r;
    end
  end

  // Response FSM with registered rsp_valid/rsp_id/rsp_le; STALL freezes the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_le_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_s) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= load_id_s;
            rsp_le_r    <= load_le_s;
          end else begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
          end
        end
        ST_RESP, ST_STALL: begin
          if (bus.rsp_ready && load_s) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= load_id_s;
            rsp_le_r    <= load_le_s;
          end else if (bus.rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
          end else begin
            state_r     <= ST_STALL;
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_le    = rsp_le_r;

endmodule
